fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC, drives the instruction-memory address, and owns the IF/ID pipeline register. It consumes the hazard detection unit's stall and the ID-stage jump/branch redirect. A debug-controlled run/step/halt state machine lets the UART debug unit start, single-step and drain the pipeline on HALT.

---
 rtl/mips_pkg.sv | 16 +
 rtl/if_id_register.sv | 56 +++++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM encoding and fetch-stage constants.
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE   = 3'd0,
    FETCH_RUN    = 3'd1,
    FETCH_STEP   = 3'd2,
    FETCH_DRAIN  = 3'd3,
    FETCH_HALTED = 3'd4
  } fetch_state_e;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          PC_INCR    = 4;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register with hold (stall) and flush (NOP) controls; hold wins over flush.
module if_id_register
  import mips_pkg::*;
#(
  parameter int NB_PC    = 32,
  parameter int NB_INSTR = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_hold,
  input  logic                i_flush,
  input  logic [NB_INSTR-1:0] i_instr,
  input  logic [NB_PC-1:0]    i_pc_plus4,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc_plus4,
  output logic                o_valid
);

  logic [NB_INSTR-1:0] instr_q, instr_d;
  logic [NB_PC-1:0]    pc_plus4_q, pc_plus4_d;
  logic                valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (i_hold) begin
      instr_d    = instr_q;
    end else if (i_flush) begin
      instr_d    = NB_INSTR'(NOP_INSTR);
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else begin
      instr_d    = i_instr;
      pc_plus4_d = i_pc_plus4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign o_instr    = instr_q;
  assign o_pc_plus4 = pc_plus4_q;
  assign o_valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register and debug run/step/halt/drain FSM.
// Optional stall-cycle counter enabled by defining FETCH_STALL_COUNT_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int               NB_PC        = 32,
  parameter int               NB_INSTR     = 32,
  parameter logic [NB_PC-1:0] PC_RESET     = '0,
  parameter int               DRAIN_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_stall,
  input  logic                i_jump,
  input  logic [NB_PC-1:0]    i_jump_addr,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_halt_req,
  input  logic [NB_INSTR-1:0] i_instr,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_INSTR-1:0] o_IF_ID_instr,
  output logic [NB_PC-1:0]    o_IF_ID_pc_plus4,
  output logic                o_IF_ID_valid,
  output logic [2:0]          o_state,
  output logic                o_halted,
  output logic [31:0]         o_stall_count
);

  localparam int                  NB_DRAIN = $clog2(DRAIN_CYCLES + 1);
  localparam logic [NB_INSTR-1:0] HALT_W   = NB_INSTR'(HALT_INSTR);

  fetch_state_e        state_q, state_d;
  logic [NB_PC-1:0]    pc_q, pc_d;
  logic [NB_DRAIN-1:0] drain_q, drain_d;
  logic [NB_PC-1:0]    pc_plus4;
  logic                ifid_hold, ifid_flush;
  logic                unused_jump_lsb;

  // Redirect targets are forced word-aligned, so the two low bits never matter.
  assign unused_jump_lsb = ^i_jump_addr[1:0];
  assign pc_plus4        = pc_q + NB_PC'(PC_INCR);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_d    = drain_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        ifid_flush = 1'b1;
        if (i_run)       state_d = FETCH_RUN;
        else if (i_step) state_d = FETCH_STEP;
      end
      FETCH_RUN, FETCH_STEP: begin
        if (i_stall) begin
          ifid_hold = 1'b1;
        end else if (i_jump) begin
          pc_d       = {i_jump_addr[NB_PC-1:2], 2'b00};
          ifid_flush = 1'b1;
          if (state_q == FETCH_STEP) state_d = FETCH_IDLE;
        end else if (i_instr == HALT_W) begin
          drain_d = NB_DRAIN'(DRAIN_CYCLES);
          state_d = FETCH_DRAIN;
        end else begin
          pc_d = pc_plus4;
          if (state_q == FETCH_STEP) state_d = FETCH_IDLE;
        end
        // A debug halt lets this cycle's action finish; a fetched HALT takes precedence.
        if (state_q == FETCH_RUN && i_halt_req && state_d != FETCH_DRAIN)
          state_d = FETCH_IDLE;
      end
      FETCH_DRAIN: begin
        if (i_stall) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_flush = 1'b1;
          drain_d    = drain_q - NB_DRAIN'(1);
          if (drain_q == NB_DRAIN'(1)) state_d = FETCH_HALTED;
        end
      end
      FETCH_HALTED: begin
        ifid_flush = 1'b1;
      end
      default: begin
        ifid_flush = 1'b1;
        state_d    = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FETCH_IDLE;
      pc_q    <= PC_RESET;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
    end
  end

  if_id_register #(
    .NB_PC    (NB_PC),
    .NB_INSTR (NB_INSTR)
  ) u_if_id (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_hold     (ifid_hold),
    .i_flush    (ifid_flush),
    .i_instr    (i_instr),
    .i_pc_plus4 (pc_plus4),
    .o_instr    (o_IF_ID_instr),
    .o_pc_plus4 (o_IF_ID_pc_plus4),
    .o_valid    (o_IF_ID_valid)
  );

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_stall && stall_cnt_q != 32'hFFFF_FFFF &&
        (state_q == FETCH_RUN || state_q == FETCH_STEP || state_q == FETCH_DRAIN))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_count = stall_cnt_q;
`else
  assign o_stall_count = '0;
`endif

  assign o_pc     = pc_q;
  assign o_state  = state_q;
  assign o_halted = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus randomized episodes vs a behavioural model.
module tb_fetch_stage;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump, run, step, halt;
  logic [31:0] jaddr;
  logic [31:0] instr;
  logic [31:0] pc, ifid_instr, ifid_pcp4, stall_count;
  logic        ifid_valid, halted;
  logic [2:0]  state;

  logic [31:0] mem [0:63];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic [2:0]  st;
    logic        halted;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_pcp4, m_sc;
  logic        m_valid;
  int          m_st, m_drain;

  always #5 clk = ~clk;

  assign instr = mem[pc[7:2]];

  fetch_stage #(
    .NB_PC        (32),
    .NB_INSTR     (32),
    .PC_RESET     (32'h0),
    .DRAIN_CYCLES (DC)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stall          (stall),
    .i_jump           (jump),
    .i_jump_addr      (jaddr),
    .i_run            (run),
    .i_step           (step),
    .i_halt_req       (halt),
    .i_instr          (instr),
    .o_pc             (pc),
    .o_IF_ID_instr    (ifid_instr),
    .o_IF_ID_pc_plus4 (ifid_pcp4),
    .o_IF_ID_valid    (ifid_valid),
    .o_state          (state),
    .o_halted         (halted),
    .o_stall_count    (stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
    m_st = 0; m_drain = 0; m_sc = 32'h0;
  endtask

  task automatic model_nop();
    m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
  endtask

  // One clock of the fetch rules; state numbers are IDLE=0 RUN=1 STEP=2 DRAIN=3 HALTED=4.
  task automatic model_step(input logic s, j, input logic [31:0] a, input logic r, sp, h);
    logic [31:0] w;
    int          ns;
    exp_t        e;
    w  = mem[m_pc[7:2]];
    ns = m_st;
`ifdef FETCH_STALL_COUNT_EN
    if (s && m_st >= 1 && m_st <= 3 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
`endif
    case (m_st)
      0: begin
        model_nop();
        if (r) ns = 1; else if (sp) ns = 2;
      end
      1, 2: begin
        if (s) begin
          // frozen
        end else if (j) begin
          m_pc = a & 32'hFFFF_FFFC;
          model_nop();
          if (m_st == 2) ns = 0;
        end else if (w == 32'hFFFF_FFFF) begin
          m_instr = w; m_pcp4 = m_pc + 4; m_valid = 1'b1;
          m_drain = DC; ns = 3;
        end else begin
          m_instr = w; m_pcp4 = m_pc + 4; m_valid = 1'b1;
          m_pc = m_pc + 4;
          if (m_st == 2) ns = 0;
        end
        if (m_st == 1 && h && ns != 3) ns = 0;
      end
      3: begin
        if (!s) begin
          model_nop();
          if (m_drain == 1) ns = 4;
          m_drain = m_drain - 1;
        end
      end
      default: model_nop();
    endcase
    m_st = ns;
    e.pc = m_pc; e.instr = m_instr; e.pcp4 = m_pcp4; e.valid = m_valid;
    e.st = 3'(m_st); e.halted = (m_st == 4); e.sc = m_sc;
    q.push_back(e);
  endtask

  task automatic cyc(input logic s, j, input logic [31:0] a, input logic r, sp, h);
    @(negedge clk);
    stall = s; jump = j; jaddr = a; run = r; step = sp; halt = h;
    model_step(s, j, a, r, sp, h);
    @(posedge clk);
  endtask

  task automatic idle_in();
    stall = 0; jump = 0; jaddr = 0; run = 0; step = 0; halt = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},    pc,          32'h0);
    chk({tag, "_instr"}, ifid_instr,  32'h0);
    chk({tag, "_pcp4"},  ifid_pcp4,   32'h0);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'h0);
    chk({tag, "_state"}, 32'(state),  32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_scount"}, stall_count, 32'h0);
  endtask

  // Asynchronous reset applied between clock edges, checked before any edge occurs.
  task automatic do_reset(input string tag);
    @(negedge clk);
    idle_in();
    #1 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc",      pc,          e.pc);
      chk("ifid_instr", ifid_instr, e.instr);
      chk("ifid_pcp4",  ifid_pcp4,  e.pcp4);
      chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
      chk("state",   32'(state),  32'(e.st));
      chk("halted",  32'(halted), 32'(e.halted));
      chk("stall_count", stall_count, e.sc);
    end
  end

  initial begin
    idle_in();
    model_reset();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0022_1820 + 32'(i);
    mem[12] = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #12 check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // sequential fetch, stall then redirect to 0x43 -> 0x40
    cyc(0, 0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h43, 0, 0, 0);
    cyc(0, 1, 32'h43, 0, 0, 0);
    // jump to 0x20 together with halt request, then idle stalls/jumps ignored
    cyc(0, 1, 32'h20, 0, 0, 1);
    cyc(1, 1, 32'h88, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // single step with a stall first, then a second step
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // run into HALT at 0x30, one stall during drain, run ignored afterwards
    cyc(0, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h100, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    // PC wrap and HALT fetched together with a halt request, reset mid-drain
    mem[0] = 32'hFFFF_FFFF;
    do_reset("rst1");
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    do_reset("mid_drain");

    // stall counting: stalls in RUN and in IDLE
    mem[0] = 32'h0022_1820;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);

    // randomized episodes
    for (int ep = 0; ep < 8; ep++) begin
      do_reset("ep_rst");
      for (int i = 0; i < 64; i++)
        mem[i] = ($urandom_range(0, 23) == 0) ? 32'hFFFF_FFFF : ($urandom & 32'h7FFF_FFFF);
      cyc(0, 0, 0, 1, 0, 0);
      for (int c = 0; c < 150; c++)
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 24) == 0);
    end

    @(negedge clk);
    idle_in();
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
